// File: rtl/game2048_pkg.sv
// Shared encodings for the 2048 game controller: board size, move directions,
// sequencer states and the spawn-position LFSR step.
package game2048_pkg;

  localparam int BOARD_CELLS = 16;
  localparam int IDX_W       = 4;
  localparam int LFSR_W      = 16;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_WAIT_IN = 3'd1,
    ST_MOVE    = 3'd2,
    ST_SPAWN   = 3'd3,
    ST_CHECK   = 3'd4,
    ST_WIN     = 3'd5,
    ST_LOSE    = 3'd6
  } state_t;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/move_sequencer_spawn_picker.sv
// Rotating-priority search for the first empty cell at or after 'start',
// wrapping past the last cell.
module spawn_picker
  import game2048_pkg::*;
(
  input  logic [BOARD_CELLS-1:0] empty_mask,
  input  logic [IDX_W-1:0]       start,
  output logic [IDX_W-1:0]       idx,
  output logic                   found
);

  // Walk from the farthest offset back to zero so the nearest hit wins.
  always_comb begin
    idx   = start;
    found = |empty_mask;
    for (int i = BOARD_CELLS - 1; i >= 0; i--) begin
      if (empty_mask[start + IDX_W'(i)])
        idx = start + IDX_W'(i);
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Game-flow sequencer for 2048: turns button edges into board-shift requests,
// places a new tile after every effective move and detects win/lose.
module move_sequencer
  import game2048_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   restart,
  output logic                   move_req,
  output logic [1:0]             move_dir,
  input  logic                   move_ack,
  input  logic                   move_changed,
  output logic                   spawn_req,
  output logic [IDX_W-1:0]       spawn_idx,
  input  logic                   spawn_ack,
  input  logic [BOARD_CELLS-1:0] empty_mask,
  input  logic                   can_merge,
  input  logic                   win_flag,
  output logic                   board_clr,
  output logic                   busy,
  output logic                   game_won,
  output logic                   game_over
);

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [3:0]        btn;
  logic [3:0]        btn_q;
  logic [3:0]        press;
  logic              restart_q;
  logic              restart_edge;
  dir_t              press_dir;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  assign btn          = {btn_right, btn_left, btn_down, btn_up};
  assign press        = btn & ~btn_q;
  assign restart_edge = restart & ~restart_q;

  // Later assignments override earlier ones, so Up ends up with top priority.
  always_comb begin
    press_dir = DIR_RIGHT;
    if (press[2]) press_dir = DIR_LEFT;
    if (press[1]) press_dir = DIR_DOWN;
    if (press[0]) press_dir = DIR_UP;
  end

  spawn_picker u_picker (
    .empty_mask (empty_mask),
    .start      (lfsr[IDX_W-1:0]),
    .idx        (pick_idx),
    .found      (pick_found)
  );

  assign board_clr = (state == ST_INIT);
  assign busy      = (state == ST_INIT) || (state == ST_MOVE) ||
                     (state == ST_SPAWN) || (state == ST_CHECK);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_INIT;
      lfsr      <= LFSR_SEED;
      btn_q     <= '0;
      restart_q <= 1'b0;
      move_req  <= 1'b0;
      move_dir  <= DIR_UP;
      spawn_req <= 1'b0;
      spawn_idx <= '0;
      game_won  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      lfsr      <= lfsr_next(lfsr);
      btn_q     <= btn;
      restart_q <= restart;

      case (state)
        ST_INIT: begin
          game_won  <= 1'b0;
          game_over <= 1'b0;
          if (pick_found) begin
            state     <= ST_SPAWN;
            spawn_req <= 1'b1;
            spawn_idx <= pick_idx;
          end else begin
            state <= ST_CHECK;
          end
        end

        ST_WAIT_IN: begin
          if (restart_edge) begin
            state <= ST_INIT;
          end else if (|press) begin
            state    <= ST_MOVE;
            move_req <= 1'b1;
            move_dir <= press_dir;
          end
        end

        ST_MOVE: begin
          if (move_ack) begin
            move_req <= 1'b0;
            if (!move_changed) begin
              state <= ST_WAIT_IN;
            end else if (pick_found) begin
              state     <= ST_SPAWN;
              spawn_req <= 1'b1;
              spawn_idx <= pick_idx;
            end else begin
              // Board full after the shift: nothing to place, go judge it.
              state <= ST_CHECK;
            end
          end
        end

        ST_SPAWN: begin
          if (spawn_ack) begin
            spawn_req <= 1'b0;
            state     <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (win_flag) begin
            state    <= ST_WIN;
            game_won <= 1'b1;
          end else if ((empty_mask == '0) && !can_merge) begin
            state     <= ST_LOSE;
            game_over <= 1'b1;
          end else begin
            state <= ST_WAIT_IN;
          end
        end

        ST_WIN, ST_LOSE: begin
          if (restart_edge) begin
            state     <= ST_INIT;
            game_won  <= 1'b0;
            game_over <= 1'b0;
          end
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed and randomized checks of the 2048 move sequencer against a
// behavioural model of the spawn-position search and the free-running LFSR.
module tb_move_sequencer;

  localparam logic [15:0] SEED = 16'hACE5;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        btn_up, btn_down, btn_left, btn_right, restart;
  logic        move_req, move_ack, move_changed;
  logic [1:0]  move_dir;
  logic        spawn_req, spawn_ack;
  logic [3:0]  spawn_idx;
  logic [15:0] empty_mask;
  logic        can_merge, win_flag;
  logic        board_clr, busy, game_won, game_over;

  move_sequencer #(.LFSR_SEED(SEED)) dut (
    .Clk(Clk), .Reset(Reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .restart(restart),
    .move_req(move_req), .move_dir(move_dir), .move_ack(move_ack), .move_changed(move_changed),
    .spawn_req(spawn_req), .spawn_idx(spawn_idx), .spawn_ack(spawn_ack),
    .empty_mask(empty_mask), .can_merge(can_merge), .win_flag(win_flag),
    .board_clr(board_clr), .busy(busy), .game_won(game_won), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int move_rises = 0;
  int overlap = 0;
  int exp_moves = 0;
  logic mr_q = 1'b0;

  // Reference LFSR: m_prev is the value the DUT used at the most recent edge.
  logic [15:0] m_cur = SEED;
  logic [15:0] m_prev = SEED;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_cur  = SEED;
      m_prev = SEED;
    end else begin
      m_prev = m_cur;
      m_cur  = lfsr_step(m_cur);
    end
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      if (move_req && !mr_q) move_rises++;
      mr_q = move_req;
      if (move_req && spawn_req) overlap++;
    end
  end

  function automatic int exp_pick(input logic [15:0] m, input logic [3:0] s);
    for (int i = 0; i < 16; i++)
      if (m[(int'(s) + i) % 16]) return (int'(s) + i) % 16;
    return -1;
  endfunction

  function automatic int exp_dir(input logic [3:0] b);
    if (b[0]) return 0;
    if (b[1]) return 1;
    if (b[2]) return 2;
    return 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic finish_spawn(input string tag);
    spawn_ack = 1'b1;
    tick();
    spawn_ack = 1'b0;
    check({tag, "_spawn_drop"}, spawn_req, 1'b0);
    check({tag, "_check_busy"}, busy, 1'b1);
    tick();
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [3:0]  b;
    logic [15:0] mask;
    logic        chg;
    int          w;
    int          rises0;
    int          stuck;

    set_btn(4'b0000);
    restart = 1'b0; move_ack = 1'b0; move_changed = 1'b0; spawn_ack = 1'b0;
    empty_mask = 16'hFFFF; can_merge = 1'b0; win_flag = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_move_req", move_req, 1'b0);
    check("rst_spawn_req", spawn_req, 1'b0);
    check("rst_move_dir", move_dir, 2'd0);
    check("rst_spawn_idx", spawn_idx, 4'd0);
    check("rst_game_won", game_won, 1'b0);
    check("rst_game_over", game_over, 1'b0);
    check("rst_busy", busy, 1'b1);

    // Power-up: one INIT cycle with board_clr, then spawn at seed nibble 5
    Reset = 1'b0;
    check("init_board_clr", board_clr, 1'b1);
    tick();
    check("init_clr_once", board_clr, 1'b0);
    check("init_spawn_req", spawn_req, 1'b1);
    check("init_spawn_idx5", spawn_idx, 4'd5);
    check("init_spawn_model", spawn_idx, 32'(exp_pick(16'hFFFF, m_prev[3:0])));
    finish_spawn("init");

    // Up and Right together: Up wins; unchanged board returns without spawn
    set_btn(4'b1001);
    tick();
    exp_moves++;
    check("prio_move_req", move_req, 1'b1);
    check("prio_move_dir", move_dir, 2'd0);
    move_ack = 1'b1; move_changed = 1'b0;
    tick();
    move_ack = 1'b0;
    check("nochg_move_drop", move_req, 1'b0);
    check("nochg_no_spawn", spawn_req, 1'b0);
    check("nochg_idle", busy, 1'b0);
    set_btn(4'b0000);
    tick();
    check("nochg_no_spawn2", spawn_req, 1'b0);

    // Left pulsed while waiting on a slow ack is dropped
    rises0 = move_rises;
    set_btn(4'b0010);
    tick();
    exp_moves++;
    set_btn(4'b0000);
    check("slow_dir_down", move_dir, 2'd1);
    set_btn(4'b0100);
    tick();
    set_btn(4'b0000);
    repeat (4) tick();
    check("slow_req_held", move_req, 1'b1);
    check("slow_dir_stable", move_dir, 2'd1);
    move_ack = 1'b1; move_changed = 1'b0;
    tick();
    move_ack = 1'b0;
    check("slow_req_drop", move_req, 1'b0);
    stuck = 0;
    repeat (6) begin
      tick();
      if (move_req) stuck++;
    end
    check("slow_no_replay", stuck, 0);
    check("slow_one_txn", move_rises - rises0, 1);

    // Spawn search wraps past cell 15 when LFSR nibble is 14
    empty_mask = 16'h0003;
    set_btn(4'b0100);
    tick();
    exp_moves++;
    set_btn(4'b0000);
    check("wrap_dir_left", move_dir, 2'd2);
    w = 0;
    while (m_cur[3:0] != 4'd14 && w < 200) begin
      tick();
      w++;
    end
    check("wrap_lfsr_wait_ok", (w < 200), 1'b1);
    move_ack = 1'b1; move_changed = 1'b1;
    tick();
    move_ack = 1'b0;
    check("wrap_move_drop", move_req, 1'b0);
    check("wrap_spawn_req", spawn_req, 1'b1);
    check("wrap_spawn_idx0", spawn_idx, 4'd0);
    finish_spawn("wrap");

    // Full board, shift changed, win and lose both true: win takes it
    set_btn(4'b1000);
    tick();
    exp_moves++;
    set_btn(4'b0000);
    empty_mask = 16'h0000; can_merge = 1'b0; win_flag = 1'b1;
    move_ack = 1'b1; move_changed = 1'b1;
    tick();
    move_ack = 1'b0;
    check("win_no_spawn", spawn_req, 1'b0);
    check("win_check_busy", busy, 1'b1);
    tick();
    check("win_game_won", game_won, 1'b1);
    check("win_game_over", game_over, 1'b0);
    check("win_idle", busy, 1'b0);
    set_btn(4'b0001);
    tick();
    set_btn(4'b0000);
    check("win_ignores_btn", move_req, 1'b0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("win_restart_clr", board_clr, 1'b1);
    check("win_restart_busy", busy, 1'b1);
    check("win_cleared", game_won, 1'b0);
    empty_mask = 16'hFFFF; win_flag = 1'b0;
    tick();
    check("win_restart_clr_once", board_clr, 1'b0);
    check("win_respawn_idx", spawn_idx, 32'(exp_pick(16'hFFFF, m_prev[3:0])));
    finish_spawn("win");

    // Full board with no merges: lose, then buttons do nothing
    set_btn(4'b0001);
    tick();
    exp_moves++;
    set_btn(4'b0000);
    empty_mask = 16'h0000; can_merge = 1'b0;
    move_ack = 1'b1; move_changed = 1'b1;
    tick();
    move_ack = 1'b0;
    check("lose_check_busy", busy, 1'b1);
    tick();
    check("lose_game_over", game_over, 1'b1);
    check("lose_game_won", game_won, 1'b0);
    for (int k = 0; k < 4; k++) begin
      set_btn(4'(1 << k));
      tick();
      set_btn(4'b0000);
      tick();
      check("lose_ignores_btn", move_req, 1'b0);
    end
    check("lose_held", game_over, 1'b1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    empty_mask = 16'hFFFF;
    check("lose_restart_clr", board_clr, 1'b1);
    check("lose_cleared", game_over, 1'b0);
    tick();
    check("lose_respawn_req", spawn_req, 1'b1);
    finish_spawn("lose");

    // Restart beats a same-cycle button press in WAIT_IN
    restart = 1'b1;
    set_btn(4'b0001);
    tick();
    restart = 1'b0;
    set_btn(4'b0000);
    check("rsprio_clr", board_clr, 1'b1);
    check("rsprio_no_move", move_req, 1'b0);
    tick();
    check("rsprio_spawn_idx", spawn_idx, 32'(exp_pick(16'hFFFF, m_prev[3:0])));
    finish_spawn("rsprio");

    // Randomized moves against the reference model
    can_merge = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b    = 4'($urandom_range(1, 15));
      mask = 16'($urandom);
      if ($urandom_range(0, 3) == 0) mask = 16'h0000;
      chg  = 1'($urandom_range(0, 1));
      empty_mask = mask;
      set_btn(b);
      tick();
      exp_moves++;
      set_btn(4'b0000);
      check("rnd_move_req", move_req, 1'b1);
      check("rnd_move_dir", move_dir, 32'(exp_dir(b)));
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("rnd_req_hold", move_req, 1'b1);
      end
      move_ack = 1'b1; move_changed = chg;
      tick();
      move_ack = 1'b0;
      check("rnd_move_drop", move_req, 1'b0);
      if (chg && mask != 16'h0000) begin
        check("rnd_spawn_req", spawn_req, 1'b1);
        check("rnd_spawn_idx", spawn_idx, 32'(exp_pick(mask, m_prev[3:0])));
        repeat ($urandom_range(0, 2)) begin
          tick();
          check("rnd_spawn_hold", spawn_req, 1'b1);
        end
        finish_spawn("rnd");
      end else if (chg) begin
        check("rnd_full_no_spawn", spawn_req, 1'b0);
        check("rnd_full_check", busy, 1'b1);
        tick();
        check("rnd_full_idle", busy, 1'b0);
        check("rnd_full_not_over", game_over, 1'b0);
      end else begin
        check("rnd_nochg_no_spawn", spawn_req, 1'b0);
        check("rnd_nochg_idle", busy, 1'b0);
      end
    end

    repeat (3) tick();
    check("total_move_txns", move_rises, exp_moves);
    check("req_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the nonzero reset value of the spawn-position LFSR.
REQ-002 SHALL have port Clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports btn_up, btn_down, btn_left, btn_right  input  1 each  synchronized level buttons.
REQ-005 SHALL have port restart  input  1  synchronized level, new-game request.
REQ-006 SHALL have ports move_req  output  1, move_dir  output  2, move_ack  input  1  board-shift handshake.
REQ-007 SHALL have port move_changed  input  1  board differs after shift, valid with move_ack.
REQ-008 SHALL have ports spawn_req  output  1, spawn_idx  output  4 (row*4+col), spawn_ack  input  1  tile-place handshake.
REQ-009 SHALL have ports empty_mask  input  16, can_merge  input  1, win_flag  input  1  live board status.
REQ-010 SHALL have ports board_clr  output  1, busy  output  1, game_won  output  1, game_over  output  1.

Function
REQ-011 SHALL implement states INIT, WAIT_IN, MOVE, SPAWN, CHECK, WIN, LOSE.
REQ-012 SHALL detect presses as rising edges: press = btn & ~btn_q, where btn_q is the previous cycle's value.
REQ-013 SHALL resolve simultaneous presses by priority Up > Down > Left > Right.
REQ-014 SHALL ignore presses in every state except WAIT_IN; presses are neither queued nor replayed.
REQ-015 SHALL encode move_dir as Up=0, Down=1, Left=2, Right=3; move_dir is latched on entry to MOVE and held stable while move_req=1.
REQ-016 SHALL assert board_clr for exactly one cycle in INIT, then go to SPAWN.
REQ-017 SHALL, in WAIT_IN, on a press go to MOVE the next cycle; move_req is registered, high from the MOVE entry cycle.
REQ-018 SHALL hold move_req high until move_ack is sampled high, then drop it the next cycle.
REQ-019 SHALL, on move_ack, go to SPAWN if move_changed=1, else go to WAIT_IN with no spawn.
REQ-020 SHALL drive spawn_idx as the first index k with empty_mask[k]=1, scanning from lfsr[3:0] upward modulo 16; spawn_idx is latched on SPAWN entry.
REQ-021 SHALL hold spawn_req high until spawn_ack, then go to CHECK.
REQ-022 SHALL, if empty_mask==0 on SPAWN entry, issue no spawn_req and go directly to CHECK.
REQ-023 SHALL evaluate CHECK in one cycle: win_flag → WIN; else empty_mask==0 && !can_merge → LOSE; else WAIT_IN. Win has priority over lose.
REQ-024 SHALL hold game_won=1 in WIN and game_over=1 in LOSE; both are terminal until restart.
REQ-025 SHALL act on a restart rising edge only in WAIT_IN, WIN or LOSE, going to INIT; restart has priority over a same-cycle button press.
REQ-026 SHALL assert busy in INIT, MOVE, SPAWN and CHECK, and deassert it in WAIT_IN, WIN and LOSE.
REQ-027 SHALL advance the 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle, free-running in all states.
REQ-028 SHALL never assert move_req and spawn_req in the same cycle.

Reset
REQ-029 SHALL, on Reset, set state=INIT, lfsr=LFSR_SEED, btn_q=0, move_req=0, spawn_req=0, move_dir=0, spawn_idx=0, game_won=0 and game_over=0.
REQ-030 SHALL, on Reset mid-handshake, drop req outputs immediately (asynchronously); INIT runs on the first clock after release, with board_clr pulsing in that cycle.

Structure
REQ-031 SHALL take the direction encoding, state encoding and BOARD_CELLS=16 from a shared package game2048_pkg.
REQ-032 SHALL place the rotate-priority empty-cell search in the sub-module spawn_picker (in: empty_mask, start; out: idx, found).

Verification
REQ-033 Reset release, empty_mask=16'hFFFF, lfsr[3:0]=5 → board_clr for 1 cycle, then spawn_req with spawn_idx=5; spawn_ack → WAIT_IN, busy=0.
REQ-034 btn_up and btn_right rise in the same cycle → move_req=1, move_dir=0; ack with move_changed=0 → WAIT_IN, no spawn_req.
REQ-035 empty_mask=16'h0003, lfsr[3:0]=14 → spawn_idx=0 (wraps past 15).
REQ-036 btn_left pulsed while in MOVE awaiting ack (ack delayed 5 cycles) → press dropped, exactly one move_req transaction.
REQ-037 CHECK with win_flag=1, empty_mask=0, can_merge=0 → WIN, game_won=1; restart edge → INIT, board_clr pulse.
REQ-038 CHECK with empty_mask=0, can_merge=0, win_flag=0 → LOSE, game_over=1; subsequent button presses → no move_req.
